// File: rtl/vproc_pkg.sv
// vproc_pkg: shared vector-unit types and helpers
// Divider request bundle, latency and operand extension
package vproc_pkg;

  localparam int unsigned DIV_TAG_W = 5;

  typedef struct packed {
    logic [31:0]          op1;
    logic [31:0]          op2;
    logic                 sgn;
    logic                 mod;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

  function automatic int unsigned div_lat(
    logic ops,
    logic dv,
    logic rs
  );
    return 32'(ops) + 32'(dv) + 32'(rs);
  endfunction

  function automatic logic [32:0] div_ext(
    logic [31:0] op,
    logic        sgn
  );
    return {sgn & op[31], op};
  endfunction

endpackage

// File: rtl/vproc_div_res_fifo.sv
// vproc_div_res_fifo: result FIFO for the divider
// Data and tag per entry, flush drops all contents
module vproc_div_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                   clk_i,
  input  logic                   sync_rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [31:0]            data_i,
  input  logic [TAG_W-1:0]       tag_i,
  input  logic                   pop_i,
  output logic [31:0]            data_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]      data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = data_q[rd_q];
  assign tag_o   = tag_q[rd_q];

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // pointer and count next state, pointers wrap naturally
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + AW'(do_push);
      rd_d  = rd_q + AW'(do_pop);
      cnt_d = cnt_q + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
    end
  end

  // pointer and count registers
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      data_q[wr_q] <= data_i;
      tag_q[wr_q]  <= tag_i;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (sync_rst_i)
    !(do_push && full_o)
  );

endmodule

// File: rtl/vproc_div_ctrl.sv
// vproc_div_ctrl: issue control for the 33-bit divider
// Extension, mod alignment, latency tracking, credits
module vproc_div_ctrl
  import vproc_pkg::*;
#(
  parameter logic        DIV_BUF_OPS = 1'b0,
  parameter logic        DIV_BUF_DIV = 1'b0,
  parameter logic        DIV_BUF_RES = 1'b0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             clk_i,
  input  logic             sync_rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_op1_i,
  input  logic [31:0]      req_op2_i,
  input  logic             req_signed_i,
  input  logic             req_mod_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [32:0]      div_op1_o,
  output logic [32:0]      div_op2_o,
  output logic             div_mod_o,
  input  logic [31:0]      div_res_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             busy_o
);

  localparam int unsigned LAT =
    div_lat(DIV_BUF_OPS, DIV_BUF_DIV, DIV_BUF_RES);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic             accept, pop;
  logic             wr_vld, push;
  logic [TAG_W-1:0] wr_tag;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic [CW-1:0]    occ_q, occ_d;

  assign req_ready_o = !flush_i
                    && (occ_q < CW'(FIFO_DEPTH));
  assign accept = req_valid_i && req_ready_o;

  assign div_op1_o = accept
    ? div_ext(req_op1_i, req_signed_i) : '0;
  assign div_op2_o = accept
    ? div_ext(req_op2_i, req_signed_i) : '0;

  if (DIV_BUF_OPS) begin : g_mod_buf
    logic mod_q;
    // mod follows the divider's operand buffer
    always_ff @(posedge clk_i) begin
      if (sync_rst_i) mod_q <= 1'b0;
      else            mod_q <= accept & req_mod_i;
    end
    assign div_mod_o = mod_q;
  end else begin : g_mod_comb
    assign div_mod_o = accept & req_mod_i;
  end

  if (LAT == 0) begin : g_lat0
    assign wr_vld = accept;
    assign wr_tag = req_tag_i;
  end else begin : g_pipe
    logic [LAT-1:0]   vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];

    // shift valid/tag along with the divider pipeline
    always_comb begin
      vld_d    = '0;
      tag_d[0] = req_tag_i;
      vld_d[0] = accept;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
      if (flush_i) vld_d = '0;
    end

    // stage registers, tags need no reset
    always_ff @(posedge clk_i) begin
      if (sync_rst_i) vld_q <= '0;
      else            vld_q <= vld_d;
      tag_q <= tag_d;
    end

    assign wr_vld = vld_q[LAT-1];
    assign wr_tag = tag_q[LAT-1];
  end

  assign push = wr_vld && !flush_i;
  assign pop  = res_ready_i && !fifo_empty;

  vproc_div_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .sync_rst_i (sync_rst_i),
    .flush_i    (flush_i),
    .push_i     (push),
    .data_i     (div_res_i),
    .tag_i      (wr_tag),
    .pop_i      (pop),
    .data_o     (res_data_o),
    .tag_o      (res_tag_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  // credits: grow on accept, shrink on pop
  always_comb begin
    occ_d = occ_q;
    if (flush_i) occ_d = '0;
    else occ_d = occ_q + CW'(accept) - CW'(pop);
  end

  // credit register
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) occ_q <= '0;
    else            occ_q <= occ_d;
  end

  assign res_valid_o = !fifo_empty;
  assign busy_o      = occ_q != '0;

  a_credit: assert property (
    @(posedge clk_i) disable iff (sync_rst_i)
    (fifo_cnt <= occ_q) && !(push && fifo_full)
  );

endmodule
